// File: rtl/seq_pkg.sv
// seq_pkg: state type and default detection pattern shared by the
// serial generator, the sequence detectors and their benches.
package seq_pkg;

   typedef enum bit [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      GAP    = 2'd3
   } gen_state_t;

   localparam logic [3:0] SEQ_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_shreg.sv
// seq_shreg: parallel-load, left-shift register with MSB out and the
// even parity of the word captured at load time.
module seq_shreg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb,
   output logic             parity
);

   logic [WIDTH-1:0] q;
   logic             par;

   // Load wins over shift so a back-to-back reload replaces the old word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q   <= '0;
         par <= 1'b0;
      end else if (load) begin
         q   <= din;
         par <= ^din;
      end else if (shift) begin
         q   <= {q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb    = q[WIDTH-1];
   assign parity = par;

endmodule

// File: rtl/seq_gen.sv
// seq_gen: MSB-first serial word transmitter with strobe and idle gap.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to each frame.
module seq_gen
   import seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             d,
   output logic             d_valid,
   output logic             done,
   output logic             busy,
   output logic [7:0]       frame_cnt
);

   localparam int            IW       = $clog2(WIDTH);
   localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);
   localparam bit            HAS_GAP  = (GAP > 0);

   gen_state_t    state, state_nx;
   logic [IW-1:0] idx, idx_nx;
   logic [3:0]    gcnt, gcnt_nx;
   logic          load, shift;
   logic          msb, par, last;

   seq_shreg #(
      .WIDTH(WIDTH)
   ) u_shreg (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (load),
      .shift  (shift),
      .din    (in_data),
      .msb    (msb),
`ifdef SEQ_GEN_PARITY_EN
      .parity (par)
`else
      .parity ()
`endif
   );

`ifdef SEQ_GEN_PARITY_EN
   assign last = (state == PARITY);
   assign d    = ((state == SHIFT) & msb) |
                 ((state == PARITY) & par);
`else
   assign par  = 1'b0;
   assign last = (state == SHIFT) && (idx == '0);
   assign d    = (state == SHIFT) & msb;
`endif

   assign in_ready = (state == IDLE) || (!HAS_GAP && last);
   assign d_valid  = (state == SHIFT) || (state == PARITY);
   assign done     = last;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      gcnt_nx  = gcnt;
      load     = 1'b0;
      shift    = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               state_nx = SHIFT;
               load     = 1'b1;
               idx_nx   = IDX_TOP;
            end
         end
         SHIFT: begin
            shift  = 1'b1;
            idx_nx = idx - IDX_ONE;
            if (idx == '0) state_nx = PARITY;
         end
         PARITY: begin
            state_nx = IDLE;
         end
         seq_pkg::GAP: begin
            gcnt_nx = gcnt + 4'd1;
            if (gcnt == GAP_LAST) state_nx = IDLE;
         end
      endcase
      // Final serial cycle: gap, back-to-back reload, or idle.
      if (last) begin
         gcnt_nx = '0;
         if (HAS_GAP) begin
            state_nx = seq_pkg::GAP;
         end else if (in_valid) begin
            state_nx = SHIFT;
            load     = 1'b1;
            idx_nx   = IDX_TOP;
         end else begin
            state_nx = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         gcnt      <= '0;
         frame_cnt <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         gcnt  <= gcnt_nx;
         if (last) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: drives a GAP=0 and a GAP=2 generator from one source and
// checks both against a queue-of-cycles frame model.
module tb_seq_gen;

   localparam int W = 4;
`ifdef SEQ_GEN_PARITY_EN
   localparam int L = W + 1;
`else
   localparam int L = W;
`endif

   typedef struct packed {
      logic d;
      logic v;
      logic dn;
      logic bsy;
   } rec_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic [1:0]   rdy, dd, dv, dn, bsy;
   logic [7:0]   fc0, fc1;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   rec_t mq0[$];
   rec_t mq1[$];
   logic [7:0] cnt0 = '0;
   logic [7:0] cnt1 = '0;

   always #5 clk = ~clk;

   seq_gen #(.WIDTH(W), .GAP(0)) u_g0 (
      .clk(clk), .reset_n(reset_n),
      .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[0]), .d(dd[0]), .d_valid(dv[0]),
      .done(dn[0]), .busy(bsy[0]), .frame_cnt(fc0)
   );

   seq_gen #(.WIDTH(W), .GAP(2)) u_g2 (
      .clk(clk), .reset_n(reset_n),
      .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[1]), .d(dd[1]), .d_valid(dv[1]),
      .done(dn[1]), .busy(bsy[1]), .frame_cnt(fc1)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic put(input int k, input rec_t r);
      if (k == 0) mq0.push_back(r);
      else        mq1.push_back(r);
   endtask

   // A frame as the cycles it occupies: data bits, optional parity,
   // GAP idle-but-busy cycles, then one idle cycle that holds off ready.
   task automatic push_frame(input int k, input logic [W-1:0] w);
      int   g;
      rec_t r;
      g = (k == 0) ? 0 : 2;
      for (int i = W - 1; i >= 0; i--) begin
         r = '{d: w[i], v: 1'b1, dn: (L == W && i == 0), bsy: 1'b1};
         put(k, r);
      end
      if (L > W) put(k, '{d: ^w, v: 1'b1, dn: 1'b1, bsy: 1'b1});
      for (int i = 0; i < g; i++)
         put(k, '{d: 1'b0, v: 1'b0, dn: 1'b0, bsy: 1'b1});
      if (g > 0) put(k, '{d: 1'b0, v: 1'b0, dn: 1'b0, bsy: 1'b0});
   endtask

   task automatic step(input logic v, input logic [W-1:0] w);
      rec_t       e;
      logic       er;
      logic [7:0] c;
      string      p;
      in_valid = v;
      in_data  = w;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         e = '0;
         if (k == 0) begin
            if (mq0.size() > 0) e = mq0.pop_front();
            er = (mq0.size() == 0);
            c  = cnt0;
         end else begin
            if (mq1.size() > 0) e = mq1.pop_front();
            er = (mq1.size() == 0);
            c  = cnt1;
         end
         p = (k == 0) ? "g0" : "g2";
         chk({p, ".d"},       8'(dd[k]),  8'(e.d));
         chk({p, ".d_valid"}, 8'(dv[k]),  8'(e.v));
         chk({p, ".done"},    8'(dn[k]),  8'(e.dn));
         chk({p, ".busy"},    8'(bsy[k]), 8'(e.bsy));
         chk({p, ".in_ready"}, 8'(rdy[k]), 8'(er));
         chk({p, ".frame_cnt"}, (k == 0) ? fc0 : fc1, c);
         if (e.dn) begin
            if (k == 0) cnt0 = cnt0 + 8'd1;
            else        cnt1 = cnt1 + 8'd1;
         end
         if (v && er) push_frame(k, w);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic mid_reset();
      #2 reset_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst.d",       8'(dd[k]),  8'd0);
         chk("rst.d_valid", 8'(dv[k]),  8'd0);
         chk("rst.done",    8'(dn[k]),  8'd0);
         chk("rst.busy",    8'(bsy[k]), 8'd0);
      end
      chk("rst.frame_cnt0", fc0, 8'd0);
      chk("rst.frame_cnt2", fc1, 8'd0);
      mq0.delete();
      mq1.delete();
      cnt0 = '0;
      cnt1 = '0;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) step(1'b0, '0);

      // Abandon a frame after its second bit.
      step(1'b1, 4'b1011);
      repeat (2) step(1'b0, '0);
      mid_reset();

      // Held valid: back-to-back on g0, gapped on g2.
      step(1'b1, 4'b1011);
      repeat (3) step(1'b1, 4'b1011);
      step(1'b1, 4'b0110);
      repeat (10) step(1'b0, '0);
      repeat (14) step(1'b1, 4'b1011);
      repeat (8) step(1'b0, '0);
      step(1'b1, 4'b0110);
      repeat (10) step(1'b0, '0);

      repeat (600) step(1'($urandom_range(0, 3) != 0), W'($urandom));

      // Long saturated run takes frame_cnt through 255 -> 0.
      repeat (1400) step(1'b1, W'($urandom));
      repeat (12) step(1'b0, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
